filter_queue_fsm: RTL and testbench

FILTER_QUEUE_FSM -- requirements
Module: filter_queue_fsm

---
 rtl/filter_queue_if.sv | 38 +++
 rtl/filter_queue_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_filter_queue_fsm.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_queue_if.sv
// filter_queue_if
//   Neighbour push channel into filter_queue_fsm.
//
//   Handshake: a transfer happens on a rising clk edge where
//   i_nb_valid and o_nb_ready are both 1. The producer may raise
//   i_nb_valid at any time. The packet fields are sampled only on a
//   transfer edge. o_nb_ready depends only on consumer state and never
//   on i_nb_valid. If i_nb_valid is 1 while o_nb_ready is 0, the
//   request is dropped and is not held pending.
//
//   Signals:
//     i_nb_pos                 [POS_W]  neighbour position packet
//     i_nb_node_id             [NODE_W] source node of the neighbour
//     i_nb_from_home_cell_flag [1]      neighbour originates in home cell
//     i_nb_valid               [1]      push request
//     o_nb_ready               [1]      queue can accept a neighbour
//
//   Modports: master = producer, slave = filter_queue_fsm.
interface filter_queue_if #(
  parameter int POS_W  = 64,
  parameter int NODE_W = 4
) ();
  logic [POS_W-1:0]  i_nb_pos;
  logic [NODE_W-1:0] i_nb_node_id;
  logic              i_nb_from_home_cell_flag;
  logic              i_nb_valid;
  logic              o_nb_ready;

  modport master (
    output i_nb_pos, i_nb_node_id, i_nb_from_home_cell_flag, i_nb_valid,
    input  o_nb_ready
  );

  modport slave (
    input  i_nb_pos, i_nb_node_id, i_nb_from_home_cell_flag, i_nb_valid,
    output o_nb_ready
  );
endinterface

// File: rtl/filter_queue_fsm.sv
// filter_queue_fsm
//   Queues incoming neighbour packets and holds one active neighbour
//   while the home particle ID sweeps through a full revolution. The
//   sweep completes when i_home_parid returns to the value it had when
//   the neighbour was loaded.
//
//   Backpressure (i_almost_full) parks the sweep in SPINNING. The
//   sweep resumes when the home particle ID returns to the checkpoint.
//   A sweep that never completes is dropped after MAX_SWEEP cycles,
//   and the sticky o_timeout flag is set.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     nb (slave)          neighbour push channel (see filter_queue_if)
//     i_home_parid        home particle currently under evaluation
//     i_almost_full       downstream backpressure
//     o_nb_reg            active neighbour packet
//     o_node_id_reg       active neighbour node ID
//     o_nb_from_home_cell active neighbour home-cell flag
//     o_filtering_flag    active neighbour is being filtered
//     o_back_pressure     filtering is paused
//     o_done              1-cycle pulse when a sweep completes
//     o_timeout           sticky sweep-timeout error
//     o_q_count           queue occupancy
//     o_dbg_state         FSM state (0 WAITING, 1 FILTERING, 2 SPINNING)
//     o_dbg_sweep         sweep counter
module filter_queue_fsm #(
  parameter int PAR_W     = 8,
  parameter int POS_W     = 64,
  parameter int NODE_W    = 4,
  parameter int QDEPTH    = 4,
  parameter int MAX_SWEEP = 1024,
  localparam int CNT_W    = $clog2(QDEPTH + 1),
  localparam int SWEEP_W  = $clog2(MAX_SWEEP)
) (
  input  logic               clk,
  input  logic               rst,
  filter_queue_if.slave      nb,
  input  logic [PAR_W-1:0]   i_home_parid,
  input  logic               i_almost_full,
  output logic [POS_W-1:0]   o_nb_reg,
  output logic [NODE_W-1:0]  o_node_id_reg,
  output logic               o_nb_from_home_cell,
  output logic               o_filtering_flag,
  output logic               o_back_pressure,
  output logic               o_done,
  output logic               o_timeout,
  output logic [CNT_W-1:0]   o_q_count,
  output logic [1:0]         o_dbg_state,
  output logic [SWEEP_W-1:0] o_dbg_sweep
);

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
    $error("filter_queue_fsm: QDEPTH must be a power of 2 and at least 2");
  end
  if (MAX_SWEEP < 2) begin : g_bad_max_sweep
    $error("filter_queue_fsm: MAX_SWEEP must be at least 2");
  end

  localparam int PTR_W = $clog2(QDEPTH);

  typedef enum logic [1:0] {
    WAITING   = 2'd0,
    FILTERING = 2'd1,
    SPINNING  = 2'd2
  } state_t;

  state_t state;

  // Queue storage. The contents need no reset because the pointers and
  // the count define which entries are valid.
  logic [POS_W-1:0]  mem_pos  [QDEPTH];
  logic [NODE_W-1:0] mem_node [QDEPTH];
  logic              mem_home [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  q_count;

  logic [PAR_W-1:0]   target;
  logic [PAR_W-1:0]   ckpt;
  logic [SWEEP_W-1:0] sweep;

  logic push;
  logic pop;
  logic q_empty;
  logic match;

  assign o_q_count     = q_count;
  assign nb.o_nb_ready = (q_count < CNT_W'(QDEPTH));
  assign push          = nb.i_nb_valid && nb.o_nb_ready;
  assign q_empty       = (q_count == '0);
  assign match         = (i_home_parid == target);

  // The head is consumed from WAITING, or on a completing match in
  // FILTERING (zero-bubble reload). Because q_count is the registered
  // count, an entry pushed into an empty queue is popped one cycle later
  // at the earliest.
  assign pop = !q_empty &&
               ((state == WAITING) || (state == FILTERING && match));

  assign o_dbg_state = state;
  assign o_dbg_sweep = sweep;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pos[wr_ptr]  <= nb.i_nb_pos;
      mem_node[wr_ptr] <= nb.i_nb_node_id;
      mem_home[wr_ptr] <= nb.i_nb_from_home_cell_flag;
    end
  end

  // The pointers wrap naturally because QDEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= WAITING;
      o_nb_reg            <= '0;
      o_node_id_reg       <= '0;
      o_nb_from_home_cell <= 1'b0;
      o_filtering_flag    <= 1'b0;
      o_back_pressure     <= 1'b0;
      o_done              <= 1'b0;
      o_timeout           <= 1'b0;
      target              <= '0;
      ckpt                <= '0;
      sweep               <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        WAITING: begin
          if (!q_empty) begin
            o_nb_reg            <= mem_pos[rd_ptr];
            o_node_id_reg       <= mem_node[rd_ptr];
            o_nb_from_home_cell <= mem_home[rd_ptr];
            target              <= i_home_parid;
            o_filtering_flag    <= 1'b1;
            sweep               <= '0;
            state               <= FILTERING;
          end
        end
        FILTERING: begin
          if (match) begin
            o_done <= 1'b1;
            if (!q_empty) begin
              // Load the next neighbour in the same cycle. The flag
              // stays high across the hand-over.
              o_nb_reg            <= mem_pos[rd_ptr];
              o_node_id_reg       <= mem_node[rd_ptr];
              o_nb_from_home_cell <= mem_home[rd_ptr];
              target              <= i_home_parid;
              sweep               <= '0;
            end else begin
              o_filtering_flag <= 1'b0;
              state            <= WAITING;
            end
          end else if (sweep == SWEEP_W'(MAX_SWEEP - 1)) begin
            // The sweep never closed. Drop the neighbour without o_done.
            o_timeout        <= 1'b1;
            o_filtering_flag <= 1'b0;
            state            <= WAITING;
          end else begin
            sweep <= sweep + SWEEP_W'(1);
            if (i_almost_full) begin
              ckpt             <= i_home_parid;
              o_filtering_flag <= 1'b0;
              o_back_pressure  <= 1'b1;
              state            <= SPINNING;
            end
          end
        end
        SPINNING: begin
          // The sweep counter is frozen here. No target check is made,
          // because the sweep resumes from ckpt.
          if (i_home_parid == ckpt && !i_almost_full) begin
            o_filtering_flag <= 1'b1;
            o_back_pressure  <= 1'b0;
            state            <= FILTERING;
          end
        end
        default: state <= WAITING;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_queue_fsm.sv
// tb_filter_queue_fsm
//   Directed bench for filter_queue_fsm. dut uses the default
//   parameters. dut_to uses MAX_SWEEP = 8 for the timeout case.
module tb_filter_queue_fsm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] parid;
  logic       almost_full;

  filter_queue_if #(.POS_W(64), .NODE_W(4)) nbif ();
  filter_queue_if #(.POS_W(64), .NODE_W(4)) nbif2 ();

  logic [63:0] nb_reg, nb_reg2;
  logic [3:0]  node_reg, node_reg2;
  logic        home_reg, home_reg2;
  logic        flag, flag2;
  logic        bp, bp2;
  logic        done, done2;
  logic        tmo, tmo2;
  logic [2:0]  qcnt, qcnt2;
  logic [1:0]  st, st2;
  logic [9:0]  sweep;
  logic [2:0]  sweep2;

  filter_queue_fsm dut (
    .clk(clk), .rst(rst), .nb(nbif),
    .i_home_parid(parid), .i_almost_full(almost_full),
    .o_nb_reg(nb_reg), .o_node_id_reg(node_reg),
    .o_nb_from_home_cell(home_reg), .o_filtering_flag(flag),
    .o_back_pressure(bp), .o_done(done), .o_timeout(tmo),
    .o_q_count(qcnt), .o_dbg_state(st), .o_dbg_sweep(sweep)
  );

  filter_queue_fsm #(.MAX_SWEEP(8)) dut_to (
    .clk(clk), .rst(rst), .nb(nbif2),
    .i_home_parid(parid), .i_almost_full(almost_full),
    .o_nb_reg(nb_reg2), .o_node_id_reg(node_reg2),
    .o_nb_from_home_cell(home_reg2), .o_filtering_flag(flag2),
    .o_back_pressure(bp2), .o_done(done2), .o_timeout(tmo2),
    .o_q_count(qcnt2), .o_dbg_state(st2), .o_dbg_sweep(sweep2)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [63:0] pos, input logic [3:0] node,
                       input logic home);
    nbif.i_nb_pos                 = pos;
    nbif.i_nb_node_id             = node;
    nbif.i_nb_from_home_cell_flag = home;
    nbif.i_nb_valid               = 1'b1;
  endtask

  int cnt_a;
  int cnt_b;

  initial begin
    parid       = 8'd0;
    almost_full = 1'b0;
    nbif.i_nb_pos = '0; nbif.i_nb_node_id = '0;
    nbif.i_nb_from_home_cell_flag = 1'b0; nbif.i_nb_valid = 1'b0;
    nbif2.i_nb_pos = '0; nbif2.i_nb_node_id = '0;
    nbif2.i_nb_from_home_cell_flag = 1'b0; nbif2.i_nb_valid = 1'b0;

    // ---- reset state ----
    rst = 1'b1;
    #1;
    check("rst_q_count", qcnt, 0);
    check("rst_ready", nbif.o_nb_ready, 1);
    check("rst_flag", flag, 0);
    check("rst_done", done, 0);
    check("rst_timeout", tmo, 0);
    check("rst_bp", bp, 0);
    check("rst_state", st, 0);
    repeat (2) tick();
    rst = 1'b0;

    // ---- single neighbour, full sweep ----
    parid = 8'd5;
    push1(64'hA, 4'd2, 1'b1);
    tick();
    nbif.i_nb_valid = 1'b0;
    check("a_count_after_push", qcnt, 1);
    check("a_still_waiting", st, 0);
    tick();
    check("a_flag_on", flag, 1);
    check("a_nb_reg", nb_reg, 64'hA);
    check("a_node", node_reg, 2);
    check("a_home", home_reg, 1);
    check("a_count_after_pop", qcnt, 0);
    check("a_state_filt", st, 1);
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 255; k++) begin
      parid = 8'(5 + k);
      tick();
      if (done) cnt_a++;
      if (!flag) cnt_b++;
    end
    check("a_no_early_done", cnt_a, 0);
    check("a_flag_held", cnt_b, 0);
    check("a_sweep_count", sweep, 255);
    parid = 8'd5;
    tick();
    check("a_done", done, 1);
    check("a_flag_off", flag, 0);
    check("a_state_wait", st, 0);
    tick();
    check("a_done_one_cycle", done, 0);
    check("a_nb_hold", nb_reg, 64'hA);
    check("a_node_hold", node_reg, 2);

    // ---- overfill the queue while a neighbour is active ----
    parid = 8'd20;
    push1(64'h100, 4'd1, 1'b0);
    tick();
    nbif.i_nb_valid = 1'b0;
    tick();
    check("b_active", nb_reg, 64'h100);
    parid = 8'd21;
    for (int k = 1; k <= 5; k++) begin
      push1(64'h10 + 64'(k), 4'(k), 1'b0);
      tick();
      if (k <= 4) exp_q.push_back(64'h10 + 64'(k));
      check($sformatf("b_count_%0d", k), qcnt, (k <= 4) ? k : 4);
      check($sformatf("b_ready_%0d", k), nbif.o_nb_ready, (k < 4) ? 1 : 0);
    end
    nbif.i_nb_valid = 1'b0;

    // ---- zero-bubble hand-over, each reload matches immediately ----
    parid = 8'd20;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("c_done_%0d", k), done, 1);
      check($sformatf("c_flag_%0d", k), flag, 1);
      check($sformatf("c_nb_%0d", k), nb_reg, exp_q.pop_front());
      check($sformatf("c_count_%0d", k), qcnt, 4 - k);
    end
    tick();
    check("c_last_done", done, 1);
    check("c_last_flag", flag, 0);
    check("c_last_state", st, 0);

    // ---- backpressure / SPINNING ----
    parid = 8'd7;
    push1(64'h200, 4'd3, 1'b0);
    tick();
    nbif.i_nb_valid = 1'b0;
    tick();
    check("d_loaded", nb_reg, 64'h200);
    check("d_sweep0", sweep, 0);
    parid = 8'd8;
    tick();
    check("d_sweep1", sweep, 1);
    parid = 8'd9;
    almost_full = 1'b1;
    tick();
    check("d_state_spin", st, 2);
    check("d_bp_on", bp, 1);
    check("d_flag_off", flag, 0);
    check("d_sweep2", sweep, 2);
    parid = 8'd10; tick();
    parid = 8'd11; tick();
    almost_full = 1'b0;
    cnt_a = 0;
    // Passes through the target value 7 and must neither match nor leave.
    for (int p = 12; p < 256 + 9; p++) begin
      parid = 8'(p);
      tick();
      if (st != 2'd2 || done) cnt_a++;
    end
    check("d_stayed_spinning", cnt_a, 0);
    check("d_bp_held", bp, 1);
    check("d_sweep_frozen", sweep, 2);
    parid = 8'd9;
    tick();
    check("d_resume_state", st, 1);
    check("d_resume_flag", flag, 1);
    check("d_resume_bp", bp, 0);
    check("d_resume_sweep", sweep, 2);
    parid = 8'd10;
    tick();
    check("d_sweep_runs", sweep, 3);
    parid = 8'd7;
    tick();
    check("d_done", done, 1);
    check("d_end_state", st, 0);

    // ---- timeout on dut_to (MAX_SWEEP = 8) ----
    parid = 8'd50;
    nbif2.i_nb_pos = 64'h300; nbif2.i_nb_node_id = 4'd5;
    nbif2.i_nb_valid = 1'b1;
    tick();
    nbif2.i_nb_pos = 64'h301; nbif2.i_nb_node_id = 4'd6;
    tick();
    nbif2.i_nb_valid = 1'b0;
    parid = 8'd51;
    check("e_loaded", nb_reg2, 64'h300);
    check("e_flag_on", flag2, 1);
    check("e_count", qcnt2, 1);
    cnt_a = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (done2) cnt_a++;
    end
    check("e_sweep7", sweep2, 7);
    check("e_no_timeout_yet", tmo2, 0);
    check("e_flag_still_on", flag2, 1);
    tick();
    if (done2) cnt_a++;
    check("e_timeout", tmo2, 1);
    check("e_flag_off", flag2, 0);
    check("e_state_wait", st2, 0);
    check("e_no_done", cnt_a, 0);
    tick();
    check("e_next_loaded", nb_reg2, 64'h301);
    check("e_next_node", node_reg2, 6);
    check("e_next_flag", flag2, 1);
    check("e_timeout_sticky", tmo2, 1);
    check("e_count_empty", qcnt2, 0);

    // ---- reset while SPINNING with 3 entries queued ----
    parid = 8'd30;
    push1(64'h400, 4'd1, 1'b0);
    tick();
    push1(64'h401, 4'd1, 1'b0);
    tick();
    parid = 8'd31;
    almost_full = 1'b1;
    push1(64'h402, 4'd1, 1'b0);
    tick();
    push1(64'h403, 4'd1, 1'b0);
    tick();
    nbif.i_nb_valid = 1'b0;
    check("f_spinning", st, 2);
    check("f_count3", qcnt, 3);
    check("f_bp", bp, 1);
    #2;
    rst = 1'b1;
    #1;
    check("f_rst_count", qcnt, 0);
    check("f_rst_bp", bp, 0);
    check("f_rst_flag", flag, 0);
    check("f_rst_ready", nbif.o_nb_ready, 1);
    check("f_rst_state", st, 0);
    check("f_rst_nb", nb_reg, 0);
    check("f_rst_timeout2", tmo2, 0);
    almost_full = 1'b0;
    tick();
    rst = 1'b0;
    parid = 8'd40;
    push1(64'h500, 4'd9, 1'b1);
    tick();
    nbif.i_nb_valid = 1'b0;
    tick();
    check("f_resume_nb", nb_reg, 64'h500);
    check("f_resume_flag", flag, 1);
    check("f_queue_discarded", qcnt, 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
